// File: rtl/imm_extend_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe_if
// Handshake bundle for the immediate-extension unit.
//   Input side : in_valid, in_ready, in_imm[IN_W], in_mode[2], in_tag[TAG_W]
//   Control    : flush (discard held entries at the next edge)
//   Output side: out_valid, out_ready, out_data[OUT_W], out_tag[TAG_W],
//                out_count[16] (accepted results since reset, wrapping)
// master = producer/consumer environment, slave = the extension unit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      out_count;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_count
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_count
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate-extension unit for the ID stage. Extends an IN_W-bit
// immediate to OUT_W bits (sign, zero, LUI upper placement, or branch offset
// = sign-extend then shift left 2), with one cycle of latency and a 2-entry
// (main + skid) output buffer so a stalled consumer never costs throughput.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - imm_extend_pipe_if.slave (in/out handshakes, flush, out_count)
// The IN_W/OUT_W/TAG_W parameters must match those of the connected bus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
);
  localparam int SH = OUT_W - IN_W;

  logic [SH-1:0]    w_fill;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;
  logic [15:0]      r_count;

  // Sign bit replicated across the SH extension bits.
  genvar gi;
  generate
    for (gi = 0; gi < SH; gi++) begin : g_fill
      assign w_fill[gi] = bus.in_imm[IN_W-1];
    end
  endgenerate

  assign w_sext = {w_fill, bus.in_imm};

  always_comb begin
    w_ext = w_sext;
    case (bus.in_mode)
      2'b00:   w_ext = w_sext;
      2'b01:   w_ext = {{SH{1'b0}}, bus.in_imm};
      2'b10:   w_ext = {bus.in_imm, {SH{1'b0}}};
      // Branch offset: the two MSBs of the sign-extended value fall off.
      default: w_ext = {w_sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // in_ready depends only on the skid flag, so there is no combinational
  // path from out_ready back to in_ready.
  assign w_in_xfer  = bus.in_valid && !r_skid_valid;
  assign w_out_xfer = r_main_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_tag   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
      r_count      <= '0;
    end else begin
      // A transfer that coincides with a flush has still been delivered.
      if (w_out_xfer) begin
        r_count <= r_count + 16'd1;
      end

      if (bus.flush) begin
        // Data registers keep their contents; only occupancy is cleared,
        // and any simultaneous input is dropped.
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_out_xfer) begin
        if (r_skid_valid) begin
          // FULL -> ONE: the older skid entry becomes the head.
          r_main_data  <= r_skid_data;
          r_main_tag   <= r_skid_tag;
          r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_main_data  <= w_ext;
          r_main_tag   <= bus.in_tag;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        if (r_main_valid) begin
          // Head is stalled: park the new result behind it.
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_ext;
          r_skid_tag   <= bus.in_tag;
        end else begin
          r_main_valid <= 1'b1;
          r_main_data  <= w_ext;
          r_main_tag   <= bus.in_tag;
        end
      end
    end
  end

  assign bus.in_ready  = !r_skid_valid;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_tag   = r_main_tag;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
// Two instances: A (IN_W=16, OUT_W=32) and B (IN_W=12, OUT_W=64). Expected
// results come from an arithmetic extension function and a FIFO queue per
// instance holding results that have been accepted but not yet delivered.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus_a ();
  imm_extend_pipe_if #(.IN_W(12), .OUT_W(64), .TAG_W(5)) bus_b ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  imm_extend_pipe #(.IN_W(12), .OUT_W(64), .TAG_W(5)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Drive / monitor arrays indexed by instance (0 = A, 1 = B).
  logic        d_valid [2];
  logic [63:0] d_imm   [2];
  logic [1:0]  d_mode  [2];
  logic [4:0]  d_tag   [2];
  logic        d_flush [2];
  logic        d_ordy  [2];
  logic        m_ir    [2];
  logic        m_ov    [2];
  logic [63:0] m_data  [2];
  logic [4:0]  m_tag   [2];
  logic [15:0] m_cnt   [2];

  assign bus_a.in_valid  = d_valid[0];
  assign bus_a.in_imm    = d_imm[0][15:0];
  assign bus_a.in_mode   = d_mode[0];
  assign bus_a.in_tag    = d_tag[0];
  assign bus_a.flush     = d_flush[0];
  assign bus_a.out_ready = d_ordy[0];
  assign bus_b.in_valid  = d_valid[1];
  assign bus_b.in_imm    = d_imm[1][11:0];
  assign bus_b.in_mode   = d_mode[1];
  assign bus_b.in_tag    = d_tag[1];
  assign bus_b.flush     = d_flush[1];
  assign bus_b.out_ready = d_ordy[1];

  assign m_ir[0]   = bus_a.in_ready;
  assign m_ov[0]   = bus_a.out_valid;
  assign m_data[0] = {32'd0, bus_a.out_data};
  assign m_tag[0]  = bus_a.out_tag;
  assign m_cnt[0]  = bus_a.out_count;
  assign m_ir[1]   = bus_b.in_ready;
  assign m_ov[1]   = bus_b.out_valid;
  assign m_data[1] = bus_b.out_data;
  assign m_tag[1]  = bus_b.out_tag;
  assign m_cnt[1]  = bus_b.out_count;

  // ---------------- reference model ----------------
  logic [63:0] qa_d[$];
  logic [4:0]  qa_t[$];
  logic [63:0] qb_d[$];
  logic [4:0]  qb_t[$];
  int          cnt   [2];
  int          xfers [2];
  int          errors = 0;
  int          checks = 0;

  function automatic int inw(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int outw(input int k);
    return (k == 0) ? 32 : 64;
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] raw, input logic [1:0] mode,
                                      input int in_w, input int out_w);
    logic [63:0] mask_in, mask_out, imm, se, r;
    mask_in  = (64'd1 << in_w) - 64'd1;
    mask_out = (out_w >= 64) ? {64{1'b1}} : ((64'd1 << out_w) - 64'd1);
    imm = raw & mask_in;
    se  = imm[in_w-1] ? (imm | ~mask_in) : imm;
    case (mode)
      2'd0:    r = se;
      2'd1:    r = imm;
      2'd2:    r = imm << (out_w - in_w);
      default: r = se << 2;
    endcase
    return r & mask_out;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? qa_d.size() : qb_d.size();
  endfunction

  function automatic void qpush(input int k, input logic [63:0] d, input logic [4:0] t);
    if (k == 0) begin qa_d.push_back(d); qa_t.push_back(t); end
    else        begin qb_d.push_back(d); qb_t.push_back(t); end
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) begin void'(qa_d.pop_front()); void'(qa_t.pop_front()); end
    else        begin void'(qb_d.pop_front()); void'(qb_t.pop_front()); end
  endfunction

  function automatic void qclear(input int k);
    if (k == 0) begin qa_d.delete(); qa_t.delete(); end
    else        begin qb_d.delete(); qb_t.delete(); end
  endfunction

  function automatic logic [63:0] qfront_d(input int k);
    return (k == 0) ? qa_d[0] : qb_d[0];
  endfunction

  function automatic logic [4:0] qfront_t(input int k);
    return (k == 0) ? qa_t[0] : qb_t[0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare every visible output against the model (called at a negedge).
  task automatic check_outputs(input int k);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".out_valid"}, 64'(m_ov[k]), 64'(qsize(k) > 0));
    chk({p, ".in_ready"},  64'(m_ir[k]), 64'(qsize(k) < 2));
    chk({p, ".out_count"}, 64'(m_cnt[k]), 64'(cnt[k]));
    if (qsize(k) > 0) begin
      chk({p, ".out_data"}, m_data[k], qfront_d(k));
      chk({p, ".out_tag"},  64'(m_tag[k]), 64'(qfront_t(k)));
    end
  endtask

  // One clock cycle: check, drive, advance the model, wait for next negedge.
  task automatic step(input int k, input bit v, input logic [63:0] imm,
                      input logic [1:0] mode, input logic [4:0] tag,
                      input bit fl, input bit ordy);
    bit in_x, out_x;
    check_outputs(k);
    d_valid[k] = v;
    d_imm[k]   = imm;
    d_mode[k]  = mode;
    d_tag[k]   = tag;
    d_flush[k] = fl;
    d_ordy[k]  = ordy;
    in_x  = v && (qsize(k) < 2);
    out_x = ordy && (qsize(k) > 0);
    if (out_x) begin
      qpop(k);
      cnt[k] = (cnt[k] + 1) & 32'hFFFF;
      xfers[k]++;
    end
    if (fl) qclear(k);
    else if (in_x) qpush(k, ext(imm, mode, inw(k), outw(k)), tag);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    step(k, 1'b0, 64'd0, 2'd0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic run_random(input int k, input int n);
    int start, cycles;
    bit v, fl, ordy, hold;
    logic [63:0] imm;
    logic [1:0]  mode;
    logic [4:0]  tag;
    start = xfers[k];
    cycles = 0;
    v = 1'b0; imm = '0; mode = '0; tag = '0;
    while ((xfers[k] - start) < n && cycles < 40000) begin
      hold = v && (qsize(k) >= 2);
      if (!hold) begin
        v    = ($urandom_range(0, 3) != 0);
        imm  = {$urandom(), $urandom()};
        mode = 2'($urandom_range(0, 3));
        tag  = 5'($urandom_range(0, 31));
      end
      ordy = ($urandom_range(0, 7) != 0);
      fl   = ($urandom_range(0, 199) == 0);
      step(k, v, imm, mode, tag, fl, ordy);
      cycles++;
    end
    if (cycles >= 40000) begin
      errors++; checks++;
      $display("FAIL random_%0d: cycle budget expired after %0d transfers, needed %0d",
               k, xfers[k] - start, n);
    end
  endtask

  logic [31:0] lit1 [4] = '{32'h00001234, 32'h00001234, 32'h12340000, 32'h000048D0};
  logic [15:0] t2_imm [5] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF};
  logic [1:0]  t2_mode[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
  logic [31:0] t2_exp [5] = '{32'hFFFFFFFF, 32'hFFFF8000, 32'h0000FFFF, 32'h00008000, 32'hFFFFFFFC};

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, g;
    for (int k = 0; k < 2; k++) begin
      d_valid[k] = 1'b0; d_imm[k] = '0; d_mode[k] = '0; d_tag[k] = '0;
      d_flush[k] = 1'b0; d_ordy[k] = 1'b1; cnt[k] = 0; xfers[k] = 0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("reset.out_valid", 64'(m_ov[0]), 64'd0);
    chk("reset.out_data",  m_data[0], 64'd0);
    chk("reset.out_tag",   64'(m_tag[0]), 64'd0);
    chk("reset.in_ready",  64'(m_ir[0]), 64'd1);
    chk("reset.out_count", 64'(m_cnt[0]), 64'd0);

    // 0x1234 in all four modes, back to back
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 64'h1234, 2'(i), 5'(i), 1'b0, 1'b1);
      chk($sformatf("t1.mode%0d", i), m_data[0], {32'd0, lit1[i]});
    end
    idle(0);
    chk("t1.count", 64'(m_cnt[0]), 64'd4);

    // Sign/zero boundaries and branch offset
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1, {48'd0, t2_imm[i]}, t2_mode[i], 5'(i + 8), 1'b0, 1'b1);
      chk($sformatf("t2.case%0d", i), m_data[0], {32'd0, t2_exp[i]});
    end
    idle(0);

    // Backpressure
    step(0, 1'b1, 64'h11, 2'd0, 5'd1, 1'b0, 1'b0);
    step(0, 1'b1, 64'h22, 2'd0, 5'd2, 1'b0, 1'b0);
    chk("t3.in_ready_full", 64'(m_ir[0]), 64'd0);
    chk("t3.head_tag",      64'(m_tag[0]), 64'd1);
    step(0, 1'b1, 64'h33, 2'd0, 5'd3, 1'b0, 1'b0);
    chk("t3.stall_data",    m_data[0], 64'h11);
    step(0, 1'b1, 64'h33, 2'd0, 5'd3, 1'b0, 1'b1);
    chk("t3.second_tag",    64'(m_tag[0]), 64'd2);
    step(0, 1'b1, 64'h33, 2'd0, 5'd3, 1'b0, 1'b1);
    chk("t3.third_tag",     64'(m_tag[0]), 64'd3);
    chk("t3.third_data",    m_data[0], 64'h33);
    idle(0);

    // Flush while FULL with a simultaneous input
    step(0, 1'b1, 64'h44, 2'd0, 5'd4, 1'b0, 1'b0);
    step(0, 1'b1, 64'h45, 2'd0, 5'd5, 1'b0, 1'b0);
    c = cnt[0];
    step(0, 1'b1, 64'h55, 2'd0, 5'd7, 1'b1, 1'b0);
    chk("t4.out_valid", 64'(m_ov[0]), 64'd0);
    chk("t4.in_ready",  64'(m_ir[0]), 64'd1);
    chk("t4.count",     64'(m_cnt[0]), 64'(c));
    repeat (3) idle(0);
    // Flush coinciding with a delivered result still counts it
    step(0, 1'b1, 64'h66, 2'd0, 5'd6, 1'b0, 1'b0);
    step(0, 1'b1, 64'h67, 2'd0, 5'd7, 1'b0, 1'b0);
    c = cnt[0];
    step(0, 1'b0, 64'h0, 2'd0, 5'd0, 1'b1, 1'b1);
    chk("t4b.count",     64'(m_cnt[0]), 64'(c + 1));
    chk("t4b.out_valid", 64'(m_ov[0]), 64'd0);
    idle(0);

    // Asynchronous reset while FULL
    step(0, 1'b1, 64'h88, 2'd1, 5'd8, 1'b0, 1'b0);
    step(0, 1'b1, 64'h99, 2'd1, 5'd9, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5.out_valid", 64'(m_ov[0]), 64'd0);
    chk("t5.out_data",  m_data[0], 64'd0);
    chk("t5.out_tag",   64'(m_tag[0]), 64'd0);
    chk("t5.in_ready",  64'(m_ir[0]), 64'd1);
    chk("t5.out_count", 64'(m_cnt[0]), 64'd0);
    for (int k = 0; k < 2; k++) begin
      qclear(k); cnt[k] = 0; xfers[k] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
    step(0, 1'b1, 64'h7FFF, 2'd0, 5'd10, 1'b0, 1'b1);
    chk("t5.post_data", m_data[0], 64'h7FFF);
    chk("t5.post_tag",  64'(m_tag[0]), 64'd10);
    idle(0);

    // Random traffic on both widths, then drive A to the counter wrap
    fork
      begin
        run_random(0, 10000);
        g = 0;
        while (xfers[0] < 65536 && g < 70000) begin
          step(0, 1'b1, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), 1'b0, 1'b1);
          g++;
          if (xfers[0] == 65535) chk("t6.count_max", 64'(m_cnt[0]), 64'hFFFF);
        end
        if (g >= 70000) begin
          errors++; checks++;
          $display("FAIL t6.wrap_budget: got %0d transfers, expected 65536", xfers[0]);
        end
        chk("t6.count_wrap", 64'(m_cnt[0]), 64'd0);
        idle(0);
      end
      begin
        run_random(1, 10000);
        idle(1);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the ID stage of the pipelined MIPS core. It accepts an IN_W-bit immediate, a mode select and a tag over a valid/ready handshake. It produces an OUT_W-bit extended, zero-extended, upper-shifted or branch-scaled result one cycle later. A 2-entry skid buffer keeps full throughput under downstream stalls, and a flush input discards in-flight entries on branch mispredict.

Parameters:
IN_W, 16, immediate input width; must be less than OUT_W.
OUT_W, 32, extended result width.
TAG_W, 5, sideband tag (destination register index) carried alongside the data.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  input immediate valid.
in_ready  output  1  unit can accept an input this cycle.
in_imm  input  IN_W  raw immediate field.
in_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper (LUI), 11 branch offset.
in_tag  input  TAG_W  sideband tag.
flush  input  1  synchronous discard of all held entries.
out_valid  output  1  output result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  OUT_W  extended result.
out_tag  output  TAG_W  tag of out_data.
out_count  output  16  number of results accepted downstream since reset; wraps.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_tag=0, skid entry empty, in_ready=1, out_count=0. Reset asserted mid-transfer drops all entries immediately.
- Arithmetic is computed combinationally on the input side and registered. SH = OUT_W-IN_W.
  - Mode 00: replicate in_imm[IN_W-1] into the upper SH bits.
  - Mode 01: fill the upper SH bits with 0.
  - Mode 10: in_imm placed in the upper IN_W bits, lower SH bits 0 (LUI).
  - Mode 11: sign-extend, then shift left 2; the top 2 bits of the sign-extended value are discarded (truncate to OUT_W).
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Storage: an output register (main) plus one skid register. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Latency: 1 cycle. Input accepted at edge N appears on out_data/out_valid after edge N.
- States (implicit in the valid bits):
  - EMPTY (main 0, skid 0): input accept -> ONE.
  - ONE (main 1, skid 0):
    - out transfer with input accept -> ONE, main replaced.
    - out transfer only -> EMPTY.
    - input accept without out transfer -> FULL, input goes to skid.
  - FULL (main 1, skid 1): in_ready=0. Out transfer -> ONE, skid moves to main.
- Ordering is strictly FIFO. No result is duplicated or dropped except by flush or reset.
- out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- Flush: at the next edge, main and skid are cleared and state becomes EMPTY.
  - Flush dominates a simultaneous input accept; that input is discarded.
  - A simultaneous out transfer in the same cycle still counts.
  - out_data keeps its last value after flush; it is a don't-care when out_valid=0.
- out_count increments by 1 on each out transfer and wraps 0xFFFF -> 0x0000. It is unaffected by flush.
- in_valid while in_ready=0 is ignored; the producer must hold its data.

Test Plan:
1. After reset, in_imm=0x1234 with modes 00, 01, 10, 11 and out_ready=1 held -> out_data 0x00001234, 0x00001234, 0x12340000, 0x000048D0 on consecutive cycles, 1-cycle latency, out_count=4.
2. in_imm=0xFFFF, then 0x8000, mode 00 -> 0xFFFFFFFF, then 0xFFFF8000. Same inputs in mode 01 -> 0x0000FFFF, 0x00008000. in_imm=0xFFFF mode 11 -> 0xFFFFFFFC.
3. Backpressure: out_ready=0, send tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, in_ready falls after the 2nd accept, tag 3 held. Release out_ready -> outputs in order 1, 2, 3, with out_data stable while stalled.
4. Flush with main and skid full, plus a simultaneous new input -> next cycle out_valid=0, in_ready=1, out_count unchanged; the new input never appears.
5. Reset asserted asynchronously between edges while FULL -> outputs 0 immediately; first post-reset input (0x7FFF, mode 00) yields 0x00007FFF.
6. Force 65536 transfers -> out_count wraps to 0x0000. Random valid/ready bench against a scoreboard model: zero mismatches over 10k transactions, for OUT_W=32/IN_W=16 and OUT_W=64/IN_W=12.
